// File: rtl/cand_pkg.sv
// Shared state encoding and parameter limits for the gated-clock controller.
// Latency: none (types and constants only).
// Backpressure: none.
package cand_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_SLEEP = 2'd2
    } ch_state_t;

    localparam int NCH_MIN    = 1;
    localparam int NCH_MAX    = 8;
    localparam int SYNC_MIN   = 2;
    localparam int SYNC_MAX   = 3;
    localparam int IDLE_W_MIN = 2;
    localparam int IDLE_W_MAX = 16;

endpackage

// File: rtl/cand_gate_ch.sv
// One gated-clock channel: enable synchroniser, OFF/ON/SLEEP FSM, idle counter, falling-edge gate flop.
// Latency: enable sampled at edge k -> ON at k+SYNC_STAGES -> gate open at the following falling edge.
// Backpressure: none; the channel always accepts its inputs.
module cand_gate_ch
    import cand_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sen,
    input  logic              auto_en,
    input  logic              act,
    input  logic [IDLE_W-1:0] idle_ld,
    output logic              gate,
    output logic              sleep
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sen_s;
    ch_state_t              state_q;
    ch_state_t              state_d;
    logic [IDLE_W-1:0]      cnt_q;
    logic [IDLE_W-1:0]      cnt_d;
    logic                   gate_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sen};
        end
    end

    assign sen_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A dropped enable wins over activity and idle expiry in every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (sen_s) state_d = ST_ON;
            end
            ST_ON: begin
                if (!sen_s) begin
                    state_d = ST_OFF;
                end else if (act) begin
                    cnt_d = idle_ld;
                end else if (auto_en) begin
                    if (cnt_q == '0) state_d = ST_SLEEP;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_SLEEP: begin
                if (!sen_s)   state_d = ST_OFF;
                else if (act) state_d = ST_ON;
            end
            default: state_d = ST_OFF;
        endcase
        if (state_q != ST_ON && state_d == ST_ON) cnt_d = idle_ld;
    end

    // Updating while the clock is low keeps every gated pulse full width.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= (state_q == ST_ON);
        end
    end

    assign gate  = gate_q;
    assign sleep = (state_q == ST_SLEEP);

endmodule

// File: rtl/cand_gate_ctrl.sv
// NCH independent glitch-free clock gates with manual or auto-sleep control.
// Latency: SEN sampled at edge k -> first IZ high phase at edge k+SYNC_STAGES+1.
// Backpressure: none.
module cand_gate_ctrl
    import cand_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_W      = 8
) (
    input  logic              CLKIN,
    input  logic              RSTN,
    input  logic [NCH-1:0]    SEN,
    input  logic [NCH-1:0]    AUTO,
    input  logic [NCH-1:0]    ACT,
    input  logic [IDLE_W-1:0] IDLE_LD,
    output logic [NCH-1:0]    IZ,
    output logic [NCH-1:0]    GSTAT,
    output logic [NCH-1:0]    SLEEP
);

    if (NCH < NCH_MIN || NCH > NCH_MAX ||
        SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX ||
        IDLE_W < IDLE_W_MIN || IDLE_W > IDLE_W_MAX) begin : g_param_err
        $error("cand_gate_ctrl: parameter out of range");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        cand_gate_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .IDLE_W      (IDLE_W)
        ) u_ch (
            .clk     (CLKIN),
            .rst_n   (RSTN),
            .sen     (SEN[i]),
            .auto_en (AUTO[i]),
            .act     (ACT[i]),
            .idle_ld (IDLE_LD),
            .gate    (GSTAT[i]),
            .sleep   (SLEEP[i])
        );
    end

    // The AND is the only cell between CLKIN and each gated clock.
    assign IZ = GSTAT & {NCH{CLKIN}};

endmodule

// File: tb/tb_cand_gate_ctrl.sv
// Directed bench for cand_gate_ctrl: opening latency, auto-sleep, wake, enable priority, reset, glitchy enables.
`timescale 1ns/1ps
module tb_cand_gate_ctrl;

    localparam int NCH    = 4;
    localparam int IDLE_W = 8;

    logic              CLKIN;
    logic              RSTN;
    logic [NCH-1:0]    SEN;
    logic [NCH-1:0]    AUTO;
    logic [NCH-1:0]    ACT;
    logic [IDLE_W-1:0] IDLE_LD;
    logic [NCH-1:0]    IZ;
    logic [NCH-1:0]    GSTAT;
    logic [NCH-1:0]    SLEEP;

    int vectors;
    int errors;

    cand_gate_ctrl #(.NCH(NCH), .SYNC_STAGES(2), .IDLE_W(IDLE_W)) dut (
        .CLKIN   (CLKIN),
        .RSTN    (RSTN),
        .SEN     (SEN),
        .AUTO    (AUTO),
        .ACT     (ACT),
        .IDLE_LD (IDLE_LD),
        .IZ      (IZ),
        .GSTAT   (GSTAT),
        .SLEEP   (SLEEP)
    );

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    // Pulse-width monitor: every gated high phase must last exactly 5 ns.
    logic [NCH-1:0] iz_prev = '0;
    realtime        rise_t [NCH];
    int             n_pulse [NCH];
    int             n_bad [NCH];
    logic           mon_en = 1'b0;

    always @(IZ) begin
        for (int i = 0; i < NCH; i++) begin
            if (IZ[i] && !iz_prev[i]) begin
                rise_t[i] = $realtime;
            end else if (!IZ[i] && iz_prev[i] && mon_en) begin
                if ($realtime - rise_t[i] == 5.0) n_pulse[i]++;
                else                              n_bad[i]++;
            end
        end
        iz_prev = IZ;
    end

    task automatic rise1;
        @(posedge CLKIN); #1;
    endtask

    task automatic fall1;
        @(negedge CLKIN); #1;
    endtask

    task automatic test_reset;
        repeat (3) rise1();
        vectors++; if (IZ !== 4'b0000)    begin errors++; $display("FAIL reset_iz: got %b want %b", IZ, 4'b0000); end
        vectors++; if (GSTAT !== 4'b0000) begin errors++; $display("FAIL reset_gstat: got %b want %b", GSTAT, 4'b0000); end
        vectors++; if (SLEEP !== 4'b0000) begin errors++; $display("FAIL reset_sleep: got %b want %b", SLEEP, 4'b0000); end
        fall1();
        RSTN = 1'b1;
        repeat (5) rise1();
    endtask

    task automatic test_open;
        fall1();
        SEN[0] = 1'b1;
        rise1();
        rise1();
        vectors++; if (GSTAT !== 4'b0000) begin errors++; $display("FAIL open_k1_gstat: got %b want %b", GSTAT, 4'b0000); end
        rise1();
        vectors++; if (GSTAT !== 4'b0000) begin errors++; $display("FAIL open_k2_gstat: got %b want %b", GSTAT, 4'b0000); end
        fall1();
        vectors++; if (GSTAT !== 4'b0001) begin errors++; $display("FAIL open_neg_gstat: got %b want %b", GSTAT, 4'b0001); end
        rise1();
        vectors++; if (IZ !== 4'b0001)    begin errors++; $display("FAIL open_first_iz: got %b want %b", IZ, 4'b0001); end
    endtask

    task automatic test_auto_sleep;
        fall1();
        AUTO[1] = 1'b1; IDLE_LD = 8'd5; SEN[1] = 1'b1;
        rise1();
        rise1();
        rise1();
        vectors++; if (SLEEP !== 4'b0000) begin errors++; $display("FAIL sleep_entry: got %b want %b", SLEEP, 4'b0000); end
        fall1();
        vectors++; if (GSTAT !== 4'b0011) begin errors++; $display("FAIL sleep_on_gstat: got %b want %b", GSTAT, 4'b0011); end
        repeat (5) rise1();
        vectors++; if (SLEEP !== 4'b0000) begin errors++; $display("FAIL sleep_5th: got %b want %b", SLEEP, 4'b0000); end
        rise1();
        vectors++; if (SLEEP !== 4'b0010) begin errors++; $display("FAIL sleep_6th: got %b want %b", SLEEP, 4'b0010); end
        vectors++; if (IZ !== 4'b0011)    begin errors++; $display("FAIL sleep_last_pulse: got %b want %b", IZ, 4'b0011); end
        fall1();
        vectors++; if (GSTAT !== 4'b0001) begin errors++; $display("FAIL sleep_gstat: got %b want %b", GSTAT, 4'b0001); end
        rise1();
        vectors++; if (IZ !== 4'b0001)    begin errors++; $display("FAIL sleep_iz_stop: got %b want %b", IZ, 4'b0001); end
    endtask

    task automatic test_wake;
        fall1();
        ACT[1] = 1'b1;
        rise1();
        vectors++; if (SLEEP !== 4'b0000) begin errors++; $display("FAIL wake_sleep: got %b want %b", SLEEP, 4'b0000); end
        vectors++; if (IZ !== 4'b0001)    begin errors++; $display("FAIL wake_no_early_iz: got %b want %b", IZ, 4'b0001); end
        fall1();
        ACT[1] = 1'b0;
        vectors++; if (GSTAT !== 4'b0011) begin errors++; $display("FAIL wake_gstat: got %b want %b", GSTAT, 4'b0011); end
        rise1();
        vectors++; if (IZ !== 4'b0011)    begin errors++; $display("FAIL wake_iz: got %b want %b", IZ, 4'b0011); end
        repeat (4) rise1();
        vectors++; if (SLEEP !== 4'b0000) begin errors++; $display("FAIL wake_reload_5th: got %b want %b", SLEEP, 4'b0000); end
        rise1();
        vectors++; if (SLEEP !== 4'b0010) begin errors++; $display("FAIL wake_reload_6th: got %b want %b", SLEEP, 4'b0010); end
    endtask

    task automatic test_zero_idle;
        fall1();
        IDLE_LD = 8'd0; AUTO[2] = 1'b1; SEN[2] = 1'b1;
        rise1();
        rise1();
        rise1();
        vectors++; if (SLEEP[2] !== 1'b0) begin errors++; $display("FAIL zero_on_sleep: got %b want %b", SLEEP[2], 1'b0); end
        fall1();
        vectors++; if (GSTAT[2] !== 1'b1) begin errors++; $display("FAIL zero_on_gstat: got %b want %b", GSTAT[2], 1'b1); end
        rise1();
        vectors++; if (SLEEP[2] !== 1'b1) begin errors++; $display("FAIL zero_sleep: got %b want %b", SLEEP[2], 1'b1); end
        vectors++; if (IZ[2] !== 1'b1)    begin errors++; $display("FAIL zero_one_pulse: got %b want %b", IZ[2], 1'b1); end
        rise1();
        vectors++; if (IZ[2] !== 1'b0)    begin errors++; $display("FAIL zero_iz_stop: got %b want %b", IZ[2], 1'b0); end
    endtask

    task automatic test_sen_priority;
        fall1();
        SEN[2] = 1'b0;
        rise1();
        rise1();
        vectors++; if (SLEEP[2] !== 1'b1) begin errors++; $display("FAIL prio_still_sleep: got %b want %b", SLEEP[2], 1'b1); end
        fall1();
        ACT[2] = 1'b1;
        rise1();
        vectors++; if (SLEEP[2] !== 1'b0) begin errors++; $display("FAIL prio_sleep: got %b want %b", SLEEP[2], 1'b0); end
        fall1();
        ACT[2] = 1'b0;
        vectors++; if (GSTAT[2] !== 1'b0) begin errors++; $display("FAIL prio_gstat: got %b want %b", GSTAT[2], 1'b0); end
        rise1();
        vectors++; if (IZ[2] !== 1'b0)    begin errors++; $display("FAIL prio_iz: got %b want %b", IZ[2], 1'b0); end
    endtask

    task automatic test_reset_mid;
        @(posedge CLKIN); #2;
        vectors++; if (IZ[0] !== 1'b1)    begin errors++; $display("FAIL rst_pre_iz: got %b want %b", IZ[0], 1'b1); end
        RSTN = 1'b0;
        #1;
        vectors++; if (IZ !== 4'b0000)    begin errors++; $display("FAIL rst_mid_iz: got %b want %b", IZ, 4'b0000); end
        vectors++; if (GSTAT !== 4'b0000) begin errors++; $display("FAIL rst_mid_gstat: got %b want %b", GSTAT, 4'b0000); end
        vectors++; if (SLEEP !== 4'b0000) begin errors++; $display("FAIL rst_mid_sleep: got %b want %b", SLEEP, 4'b0000); end
        #4;
        RSTN = 1'b1;
        rise1();
        rise1();
        rise1();
        vectors++; if (IZ[0] !== 1'b0)    begin errors++; $display("FAIL rst_k2_iz: got %b want %b", IZ[0], 1'b0); end
        rise1();
        vectors++; if (IZ[0] !== 1'b1)    begin errors++; $display("FAIL rst_k3_iz: got %b want %b", IZ[0], 1'b1); end
    endtask

    task automatic test_glitch;
        logic [NCH-1:0] g;
        fall1();
        AUTO = '0; ACT = '0;
        mon_en = 1'b1;
        for (int seg = 0; seg < 60; seg++) begin
            @(negedge CLKIN); #1;
            SEN = NCH'($urandom);
            for (int c = 0; c < 4; c++) begin
                @(negedge CLKIN); #2;
                g   = NCH'($urandom);
                SEN = SEN ^ g;
                #1;
                SEN = SEN ^ g;
            end
        end
        SEN = '0;
        repeat (5) rise1();
        mon_en = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            vectors++; if (n_bad[i] !== 0) begin errors++; $display("FAIL glitch_width ch%0d: got %0d bad pulses want 0", i, n_bad[i]); end
            vectors++; if (n_pulse[i] == 0) begin errors++; $display("FAIL glitch_pulses ch%0d: got %0d pulses want >0", i, n_pulse[i]); end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        RSTN = 1'b1; SEN = '0; AUTO = '0; ACT = '0; IDLE_LD = '0;
        #1 RSTN = 1'b0;
        test_reset();
        test_open();
        test_auto_sleep();
        test_wake();
        test_zero_idle();
        test_sen_priority();
        test_reset_mid();
        test_glitch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cand_gate_ctrl.md
CAND_GATE_CTRL -- requirements
Module: cand_gate_ctrl

Interface
REQ-001 Parameter NCH, default 4, is the number of independent gated-clock channels (legal range 1..8).
REQ-002 Parameter SYNC_STAGES, default 2, is the enable synchroniser depth (legal range 2..3).
REQ-003 Parameter IDLE_W, default 8, is the idle-counter width in bits (legal range 2..16).
REQ-004 CLKIN  input  1  free-running source clock; the block has one clock domain.
REQ-005 RSTN  input  1  asynchronous, active-low reset.
REQ-006 SEN  input  NCH  per-channel enable request, asynchronous to CLKIN.
REQ-007 AUTO  input  NCH  per-channel mode: 0 = manual, 1 = auto-sleep; synchronous to CLKIN.
REQ-008 ACT  input  NCH  per-channel activity strobe, synchronous to CLKIN.
REQ-009 IDLE_LD  input  IDLE_W  idle timeout in CLKIN cycles, shared by all channels, sampled on each counter reload.
REQ-010 IZ  output  NCH  gated clock, IZ[i] = CLKIN AND gate_q[i].
REQ-011 GSTAT  output  NCH  registered gate-open status, equal to gate_q.
REQ-012 SLEEP  output  NCH  high while the channel is in the SLEEP state.

Function
REQ-013 Each SEN[i] shall pass through a SYNC_STAGES-deep rising-edge flop chain to give sen_s[i]; no other path from SEN shall exist.
REQ-014 Each channel shall run a three-state FSM (OFF, ON, SLEEP), advanced on the CLKIN rising edge.
REQ-015 Transitions: OFF->ON when sen_s=1; ON->OFF when sen_s=0; SLEEP->OFF when sen_s=0; SLEEP->ON when ACT=1 and sen_s=1.
REQ-016 ON->SLEEP shall occur only when AUTO=1, ACT=0, sen_s=1 and the idle counter equals 0.
REQ-017 sen_s=0 shall take priority over every other condition in every state.
REQ-018 Idle counter: load IDLE_LD on entry to ON and on every ACT=1 cycle in ON; decrement by 1 in ON when AUTO=1 and ACT=0; hold at 0 with no wrap.
REQ-019 IDLE_LD=0 with AUTO=1 shall put a channel into SLEEP on the first ACT=0 cycle after entering ON.
REQ-020 gate_q[i] shall be registered on the CLKIN falling edge from (state==ON), so that IZ never shows a runt pulse or glitch.
REQ-021 Latency (SYNC_STAGES=2): SEN rising and sampled at rising edge k -> state ON at edge k+2 -> gate_q=1 at the following falling edge -> first IZ high phase begins at edge k+3.
REQ-022 Closing shall mirror opening: the IZ high phase that starts at the rising edge where the state leaves ON is the last full pulse.
REQ-023 Channels shall be fully independent; with SEN and AUTO held, one channel's activity shall not change another channel's timing.
REQ-024 Clearing AUTO while in ON shall freeze the counter; clearing AUTO while in SLEEP shall not wake the channel.

Reset
REQ-025 RSTN low shall asynchronously force: all synchroniser flops 0, all FSMs OFF, idle counters 0, gate_q 0, so IZ=0, GSTAT=0 and SLEEP=0.
REQ-026 Reset asserted mid-pulse shall drop IZ immediately; after deassertion the REQ-021 latency shall apply from scratch.
REQ-027 Reset deassertion may be asynchronous to CLKIN; the design shall tolerate this because every gate starts closed.

Structure
REQ-028 A shared package cand_pkg shall hold the FSM state enum (2-bit: OFF=0, ON=1, SLEEP=2) and the parameter range constants.
REQ-029 The per-channel logic (synchroniser, FSM, counter, negedge gate flop) shall be one sub-module, cand_gate_ch, instantiated NCH times by a generate loop.
REQ-030 Output AND gates shall be the only logic on the clock path.

Verification
REQ-031 Reset, then SEN[0] 0->1 at cycle 10, AUTO=0 -> GSTAT[0]=1 after the falling edge of cycle 12, first IZ[0] pulse at cycle 13, other channels stay 0.
REQ-032 AUTO[1]=1, IDLE_LD=5, SEN[1]=1, ACT=0 -> after ON entry, SLEEP[1]=1 on the 6th rising edge, IZ[1] stops with no partial pulse.
REQ-033 Channel 1 in SLEEP, ACT[1] pulse for one cycle -> ON next edge, IZ resumes at the following rising edge, counter reloaded to IDLE_LD.
REQ-034 SEN[2]=0 in the same cycle as ACT[2]=1 in SLEEP -> channel goes to OFF, not ON.
REQ-035 RSTN pulsed low at the midpoint of an IZ high phase -> IZ falls within the reset propagation delay, all outputs 0, re-enable latency equals 3 edges.
REQ-036 Random SEN toggling with glitches shorter than 1 cycle on all 4 channels -> assertion that every IZ high phase lasts exactly the CLKIN high phase.
